// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared memory-subsystem types and defaults
package mem_arbiter_pkg;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
  typedef enum logic {GNT_I, GNT_D} gnt_e;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant decision (bit 0 = I, bit 1 = D)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache and D-cache, one transaction at a time
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  state_e            state;
  gnt_e              last_grant;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_rd, lat_wr;
  logic [1:0]        gnt;
  logic              busy;

  rr_arb2 u_rr (
    .req  ({d_mem_read | d_mem_write, i_mem_read}),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge proc_reset_n)
    if (!proc_reset_n) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
    end else if (state == IDLE) begin
      if (gnt[0]) begin
        state      <= BUSY_I;
        last_grant <= GNT_I;
        lat_addr   <= i_mem_addr;
        lat_wdata  <= '0;
        lat_rd     <= 1'b1;
        lat_wr     <= 1'b0;
      end else if (gnt[1]) begin
        // a simultaneous read+write from the D side is executed as a write
        state      <= BUSY_D;
        last_grant <= GNT_D;
        lat_addr   <= d_mem_addr;
        lat_wdata  <= d_mem_wdata;
        lat_rd     <= ~d_mem_write;
        lat_wr     <= d_mem_write;
      end
    end else if (mem_ready)
      state <= IDLE;

  assign busy        = state != IDLE;
  assign mem_addr    = busy ? lat_addr : '0;
  assign mem_wdata   = busy ? lat_wdata : '0;
  assign mem_read    = busy & lat_rd & ~mem_ready;
  assign mem_write   = busy & lat_wr & ~mem_ready;
  assign i_mem_ready = (state == BUSY_I) & mem_ready;
  assign d_mem_ready = (state == BUSY_D) & mem_ready;
  assign i_mem_rdata = i_mem_ready ? mem_rdata : '0;
  assign d_mem_rdata = d_mem_ready ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int AW = 28;
  localparam int LW = 128;
  logic          clk = 1'b0;
  logic          proc_reset_n = 1'b0;
  logic          i_mem_read = 1'b0;
  logic [AW-1:0] i_mem_addr = '0;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read = 1'b0, d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_addr = '0;
  logic [LW-1:0] d_mem_wdata = '0;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  int            pass = 0, total = 0;
  localparam logic [LW-1:0] A5 = {16{8'hA5}};

  mem_arbiter dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_mem_read = 0; i_mem_addr = '0; d_mem_read = 0; d_mem_write = 0;
    d_mem_addr = '0; d_mem_wdata = '0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    proc_reset_n = 0;
    repeat (2) @(posedge clk);
    #1 proc_reset_n = 1;
  endtask

  task automatic test_reset();
    proc_reset_n = 0;
    i_mem_read = 1; i_mem_addr = 28'h10; mem_ready = 1; mem_rdata = A5;
    @(negedge clk);
    total++;
    if ({mem_read, mem_write, mem_addr, mem_wdata, i_mem_ready, i_mem_rdata, d_mem_ready, d_mem_rdata} !== '0)
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h iready=%b dready=%b, required all 0",
               mem_read, mem_write, mem_addr, i_mem_ready, d_mem_ready);
    else pass++;
    total++;
    if (dut.state !== IDLE || dut.last_grant !== GNT_D)
      $display("FAIL reset_state: state=%0d last=%0d, required IDLE/GNT_D", dut.state, dut.last_grant);
    else pass++;
    do_reset();
  endtask

  task automatic test_single_i();
    i_mem_read = 1; i_mem_addr = 28'h0000010;
    @(negedge clk);
    total++;
    if (mem_read !== 1'b0) $display("FAIL i_req_cycle0: mem_read=%b, required 0", mem_read);
    else pass++;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 2) i_mem_addr = 28'h0000999;
      @(negedge clk);
      total++;
      if ({mem_read, mem_write, mem_addr, i_mem_ready, d_mem_ready} !== {1'b1, 1'b0, 28'h10, 1'b0, 1'b0})
        $display("FAIL i_busy_c%0d: rd=%b wr=%b addr=%h ir=%b dr=%b, required 1 0 0000010 0 0",
                 c, mem_read, mem_write, mem_addr, i_mem_ready, d_mem_ready);
      else pass++;
    end
    step();
    mem_ready = 1; mem_rdata = A5;
    @(negedge clk);
    total++;
    if ({i_mem_ready, i_mem_rdata, d_mem_ready, d_mem_rdata, mem_read} !== {1'b1, A5, 1'b0, 128'h0, 1'b0})
      $display("FAIL i_ready: ir=%b irdata=%h dr=%b rd=%b, required 1 %h 0 0",
               i_mem_ready, i_mem_rdata, d_mem_ready, mem_read, A5);
    else pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h10;
    d_mem_write = 1; d_mem_addr = 28'h20; d_mem_wdata = 128'h1234;
    step();
    @(negedge clk);
    total++;
    if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 28'h10})
      $display("FAIL sim_first_i: rd=%b wr=%b addr=%h, required 1 0 0000010", mem_read, mem_write, mem_addr);
    else pass++;
    step();
    mem_ready = 1; mem_rdata = 128'h77;
    @(negedge clk);
    total++;
    if ({i_mem_ready, d_mem_ready, i_mem_rdata} !== {1'b1, 1'b0, 128'h77})
      $display("FAIL sim_i_ready: ir=%b dr=%b irdata=%h, required 1 0 77", i_mem_ready, d_mem_ready, i_mem_rdata);
    else pass++;
    step();
    i_mem_read = 0; mem_ready = 0;
    @(negedge clk);
    total++;
    if ({mem_read, mem_write} !== 2'b00)
      $display("FAIL sim_turnaround: rd=%b wr=%b, required 0 0", mem_read, mem_write);
    else pass++;
    step();
    @(negedge clk);
    total++;
    if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b0, 1'b1, 28'h20, 128'h1234})
      $display("FAIL sim_d_write: rd=%b wr=%b addr=%h wdata=%h, required 0 1 0000020 1234",
               mem_read, mem_write, mem_addr, mem_wdata);
    else pass++;
    step();
    mem_ready = 1;
    @(negedge clk);
    total++;
    if ({d_mem_ready, i_mem_ready, mem_write} !== 3'b100)
      $display("FAIL sim_d_ready: dr=%b ir=%b wr=%b, required 1 0 0", d_mem_ready, i_mem_ready, mem_write);
    else pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic          exp_i;
    logic [AW-1:0] exp_addr;
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h100;
    d_mem_read = 1; d_mem_addr = 28'h200;
    for (int k = 0; k < 6; k++) begin
      exp_i = (k % 2) == 0;
      exp_addr = exp_i ? 28'h100 : 28'h200;
      step();
      @(negedge clk);
      total++;
      if ({mem_read, mem_addr} !== {1'b1, exp_addr})
        $display("FAIL rr_grant%0d: rd=%b addr=%h, required 1 %h", k, mem_read, mem_addr, exp_addr);
      else pass++;
      step();
      mem_ready = 1; mem_rdata = LW'(k + 1);
      @(negedge clk);
      total++;
      if ({i_mem_ready, d_mem_ready} !== {exp_i, ~exp_i})
        $display("FAIL rr_ready%0d: ir=%b dr=%b, required %b %b", k, i_mem_ready, d_mem_ready, exp_i, ~exp_i);
      else pass++;
      step();
      mem_ready = 0;
      if (k == 5) clear_inputs();
    end
  endtask

  task automatic test_rw_both();
    d_mem_read = 1; d_mem_write = 1; d_mem_addr = 28'h30; d_mem_wdata = 128'hBEEF;
    step();
    @(negedge clk);
    total++;
    if ({mem_write, mem_read, mem_addr, mem_wdata} !== {1'b1, 1'b0, 28'h30, 128'hBEEF})
      $display("FAIL rw_both: wr=%b rd=%b addr=%h wdata=%h, required 1 0 0000030 beef",
               mem_write, mem_read, mem_addr, mem_wdata);
    else pass++;
    step();
    mem_ready = 1;
    @(negedge clk);
    total++;
    if (d_mem_ready !== 1'b1) $display("FAIL rw_ready: dr=%b, required 1", d_mem_ready);
    else pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_mem_read = 1; d_mem_addr = 28'h40;
    step();
    @(negedge clk);
    total++;
    if ({mem_read, mem_addr} !== {1'b1, 28'h40})
      $display("FAIL mid_busy: rd=%b addr=%h, required 1 0000040", mem_read, mem_addr);
    else pass++;
    #1 proc_reset_n = 0; d_mem_read = 0;
    #1;
    total++;
    if ({mem_read, mem_write, mem_addr, mem_wdata, i_mem_ready, d_mem_ready, d_mem_rdata} !== '0)
      $display("FAIL mid_abort: rd=%b wr=%b addr=%h dr=%b, required all 0", mem_read, mem_write, mem_addr, d_mem_ready);
    else pass++;
    step();
    step();
    proc_reset_n = 1; mem_ready = 1; mem_rdata = A5;
    @(negedge clk);
    total++;
    if ({i_mem_ready, d_mem_ready, i_mem_rdata, d_mem_rdata} !== '0)
      $display("FAIL mid_late_ready: ir=%b dr=%b, required 0 0", i_mem_ready, d_mem_ready);
    else pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_stray_ready();
    mem_ready = 1; mem_rdata = 128'hFF;
    @(negedge clk);
    total++;
    if ({i_mem_ready, d_mem_ready, i_mem_rdata, d_mem_rdata, mem_read, mem_write} !== '0)
      $display("FAIL stray_ready: ir=%b dr=%b rd=%b wr=%b, required all 0", i_mem_ready, d_mem_ready, mem_read, mem_write);
    else pass++;
    step();
    @(negedge clk);
    total++;
    if (dut.state !== IDLE) $display("FAIL stray_state: state=%0d, required IDLE", dut.state);
    else pass++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_simultaneous();
    test_round_robin();
    test_rw_both();
    test_reset_mid();
    test_stray_ready();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
